// File: rtl/fir_coe_loader.sv
// Host-side coefficient reload transmitter: stages COE_TAPS_TRUE words through a
// write port, then streams them in ascending order on coe_reload_vld/data.
module fir_coe_loader #(
  parameter int COE_WIDTH    = 16,
  parameter int COE_TAPS     = 3,
  parameter int COE_SYMMETRY = 0,
  parameter int ADDR_WIDTH   = 2,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_vld_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [COE_WIDTH-1:0] wr_data_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic                 coe_reload_vld_o,
  output logic [COE_WIDTH-1:0] coe_reload_data_o
);

  localparam int COE_TAPS_TRUE = (COE_SYMMETRY != 0) ? (COE_TAPS + COE_TAPS % 2) / 2 : COE_TAPS;
  localparam int KW = (COE_TAPS_TRUE > 1) ? $clog2(COE_TAPS_TRUE) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_WIDTH:0] TAPS_LIMIT = (ADDR_WIDTH + 1)'(COE_TAPS_TRUE);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [COE_WIDTH-1:0]     bank_q [COE_TAPS_TRUE];
  logic [COE_WIDTH-1:0]     bank_d [COE_TAPS_TRUE];
  logic [COE_TAPS_TRUE-1:0] bitmap_q, bitmap_d;
  logic                     vld_q, vld_d;
  logic [COE_WIDTH-1:0]     data_q, data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [1:0]               code_q, code_d;

  logic addr_ok;
  logic set_full;

  assign addr_ok  = ({1'b0, wr_addr_i} < TAPS_LIMIT);
  assign set_full = &bitmap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      gap_q    <= '0;
      bank_q   <= '{default: '0};
      bitmap_q <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      gap_q    <= gap_d;
      bank_q   <= bank_d;
      bitmap_q <= bitmap_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // A start evaluates the pre-write bitmap; a rejected start still lets the write land.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    gap_d    = gap_q;
    bank_d   = bank_q;
    bitmap_d = bitmap_q;
    case (state_q)
      IDLE: begin
        if (start_i && set_full) begin
          state_d = SEND;
          k_d     = '0;
        end else if (wr_vld_i && addr_ok) begin
          for (int i = 0; i < COE_TAPS_TRUE; i++) begin
            if (wr_addr_i == ADDR_WIDTH'(i)) begin
              bank_d[i]   = wr_data_i;
              bitmap_d[i] = 1'b1;
            end
          end
        end
      end
      SEND: begin
        if (int'(k_q) == COE_TAPS_TRUE - 1) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + KW'(1);
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : SEND;
        end
      end
      GAP: begin
        if (int'(gap_q) >= GAP_CYCLES - 1) begin
          state_d = SEND;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so word k lands one cycle after its decision.
  always_comb begin
    vld_d  = (state_d == SEND);
    busy_d = (state_d == SEND) || (state_d == GAP);
    done_d = (state_d == DONE);
    data_d = data_q;
    if (state_d == SEND) begin
      for (int i = 0; i < COE_TAPS_TRUE; i++) begin
        if (k_d == KW'(i)) data_d = bank_q[i];
      end
    end
    err_d  = 1'b0;
    code_d = 2'b00;
    if (state_q != IDLE) begin
      if (wr_vld_i) begin
        err_d  = 1'b1;
        code_d = 2'b01;
      end
    end else if (start_i) begin
      if (!set_full) begin
        err_d  = 1'b1;
        code_d = 2'b10;
      end else if (wr_vld_i) begin
        err_d  = 1'b1;
        code_d = 2'b01;
      end
    end else if (wr_vld_i && !addr_ok) begin
      err_d  = 1'b1;
      code_d = 2'b11;
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign err_code_o        = code_q;
  assign coe_reload_vld_o  = vld_q;
  assign coe_reload_data_o = data_q;

endmodule

// File: tb/tb_fir_coe_loader.sv
// Bench for fir_coe_loader: three instances (back-to-back, gapped, symmetric) share
// one stimulus stream; a reference model queues expected words/done/errors per instance.
module tb_fir_coe_loader;

  logic             clk = 1'b0;
  logic             rst;
  logic             wrVld;
  logic [1:0]       wrAddr;
  logic [15:0]      wrData;
  logic             start;
  logic [2:0]       busy, done, err, vld;
  logic [2:0][1:0]  code;
  logic [2:0][15:0] data;

  fir_coe_loader #(.COE_WIDTH(16), .COE_TAPS(3), .COE_SYMMETRY(0), .ADDR_WIDTH(2), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_vld_i(wrVld), .wr_addr_i(wrAddr), .wr_data_i(wrData), .start_i(start),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .err_code_o(code[0]),
    .coe_reload_vld_o(vld[0]), .coe_reload_data_o(data[0]));

  fir_coe_loader #(.COE_WIDTH(16), .COE_TAPS(3), .COE_SYMMETRY(0), .ADDR_WIDTH(2), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .wr_vld_i(wrVld), .wr_addr_i(wrAddr), .wr_data_i(wrData), .start_i(start),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .err_code_o(code[1]),
    .coe_reload_vld_o(vld[1]), .coe_reload_data_o(data[1]));

  fir_coe_loader #(.COE_WIDTH(16), .COE_TAPS(5), .COE_SYMMETRY(1), .ADDR_WIDTH(2), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst), .wr_vld_i(wrVld), .wr_addr_i(wrAddr), .wr_data_i(wrData), .start_i(start),
    .busy_o(busy[2]), .done_o(done[2]), .err_o(err[2]), .err_code_o(code[2]),
    .coe_reload_vld_o(vld[2]), .coe_reload_data_o(data[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = streamed word, 1 = done pulse, 2 = error pulse (val = code)
  typedef struct {
    int dut;
    int kind;
    int cyc;
    int val;
  } ev_t;

  ev_t         expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [15:0] refBank [3][3];
  logic [2:0]  refMap [3];
  int          busyLo [3];
  int          busyHi [3];
  int          refEnd [3];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int gapOf(input int d);
    return (d == 1) ? 2 : 0;
  endfunction

  task automatic pushEv(input int d, input int k, input int c, input int v);
    ev_t e;
    e.dut  = d;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    expQ.push_back(e);
  endtask

  task automatic clearModel();
    expQ.delete();
    for (int d = 0; d < 3; d++) begin
      refMap[d] = 3'b000;
      for (int k = 0; k < 3; k++) refBank[d][k] = 16'd0;
      busyLo[d] = 1;
      busyHi[d] = 0;
      refEnd[d] = -1;
    end
  endtask

  // Drives one cycle of inputs and records what each instance must do in response.
  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [15:0] dt, input logic s);
    wrVld  = w;
    wrAddr = a;
    wrData = dt;
    start  = s;
    for (int d = 0; d < 3; d++) begin
      int g;
      g = gapOf(d);
      if (cyc <= refEnd[d]) begin
        if (w) pushEv(d, 2, cyc + 1, 1);
      end else if (s && refMap[d] == 3'b111) begin
        for (int k = 0; k < 3; k++) pushEv(d, 0, cyc + 1 + k * (g + 1), int'(refBank[d][k]));
        busyLo[d] = cyc + 1;
        busyHi[d] = cyc + 3 + 2 * g;
        refEnd[d] = cyc + 4 + 2 * g;
        pushEv(d, 1, refEnd[d], 0);
        if (w) pushEv(d, 2, cyc + 1, 1);
      end else begin
        if (w && int'(a) < 3) begin
          refBank[d][int'(a)] = dt;
          refMap[d][int'(a)]  = 1'b1;
        end
        if (s) pushEv(d, 2, cyc + 1, 2);
        else if (w && int'(a) >= 3) pushEv(d, 2, cyc + 1, 3);
      end
    end
    @(posedge clk);
    #1;
    wrVld = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    logic        fired;
    logic [31:0] obs;
    int          idx;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 3; k++) begin
        fired = (k == 0) ? vld[d] : (k == 1) ? done[d] : err[d];
        obs   = (k == 0) ? 32'(data[d]) : (k == 2) ? 32'(code[d]) : 32'd0;
        idx   = -1;
        for (int i = 0; i < expQ.size(); i++) begin
          if (idx < 0 && expQ[i].dut == d && expQ[i].kind == k) idx = i;
        end
        if (fired === 1'b1) begin
          if (idx < 0) begin
            checkOutput($sformatf("spurious dut%0d ev%0d", d, k), 32'd1, 32'd0);
          end else begin
            checkOutput($sformatf("timing dut%0d ev%0d", d, k), cyc, expQ[idx].cyc);
            checkOutput($sformatf("value dut%0d ev%0d", d, k), obs, expQ[idx].val);
            expQ.delete(idx);
          end
        end else if (idx >= 0 && expQ[idx].cyc <= cyc) begin
          checkOutput($sformatf("missing dut%0d ev%0d", d, k), 32'd0, 32'd1);
          expQ.delete(idx);
        end
      end
      checkOutput($sformatf("busy dut%0d", d), 32'(busy[d]), 32'(cyc >= busyLo[d] && cyc <= busyHi[d]));
    end
  end

  initial begin
    int rnd;
    rst    = 1'b1;
    wrVld  = 1'b0;
    wrAddr = 2'd0;
    wrData = 16'd0;
    start  = 1'b0;
    clearModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset vld", 32'(vld[d]), 32'd0);
      checkOutput("reset data", 32'(data[d]), 32'd0);
      checkOutput("reset done", 32'(done[d]), 32'd0);
      checkOutput("reset err", 32'(err[d]), 32'd0);
      checkOutput("reset code", 32'(code[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    $display("[TB] basic stream");
    applyStimulus(1'b1, 2'd0, 16'd11, 1'b0);
    applyStimulus(1'b1, 2'd1, 16'd12, 1'b0);
    applyStimulus(1'b1, 2'd2, 16'd13, 1'b0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    idle(10);

    $display("[TB] out-of-range write then resend");
    applyStimulus(1'b1, 2'd3, 16'd77, 1'b0);
    idle(2);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    idle(10);

    $display("[TB] write while streaming");
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    idle(1);
    applyStimulus(1'b1, 2'd1, 16'd99, 1'b0);
    idle(10);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    idle(10);

    $display("[TB] write in the start-accept cycle");
    applyStimulus(1'b1, 2'd1, 16'd55, 1'b1);
    idle(10);

    $display("[TB] rewrite with random word");
    rnd = $urandom_range(1000, 60000);
    applyStimulus(1'b1, 2'd1, 16'(rnd), 1'b0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    idle(10);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clearModel();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("mid-reset vld", 32'(vld[d]), 32'd0);
      checkOutput("mid-reset busy", 32'(busy[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    $display("[TB] incomplete set and priorities");
    applyStimulus(1'b1, 2'd0, 16'd21, 1'b0);
    applyStimulus(1'b1, 2'd1, 16'd22, 1'b0);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    applyStimulus(1'b1, 2'd3, 16'd5, 1'b1);
    applyStimulus(1'b1, 2'd2, 16'd23, 1'b1);
    idle(1);
    applyStimulus(1'b0, 2'd0, 16'd0, 1'b1);
    idle(12);

    checkOutput("queue drained", expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
